// File: rtl/tlp_reg_responder_pkg.sv
// Shared TLP constants, header layouts and FSM state type for the register responder.
package tlp_reg_responder_pkg;

  localparam logic [7:0] MEMRD32 = 8'h00;
  localparam logic [7:0] MEMWR32 = 8'h40;
  localparam logic [7:0] CPLD    = 8'h4A;

  typedef struct packed {
    logic [7:0]  fmt_type;
    logic [13:0] attr;
    logic [9:0]  length;
  } tlp_dw0_t;

  typedef struct packed {
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [3:0]  last_be;
    logic [3:0]  first_be;
  } tlp_dw1_t;

  typedef struct packed {
    logic [15:0] completer_id;
    logic [2:0]  status;
    logic        bcm;
    logic [11:0] byte_count;
  } tlp_cpl_dw1_t;

  typedef struct packed {
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic        rsvd;
    logic [6:0]  lower_addr;
  } tlp_cpl_dw2_t;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR1, S_WRDATA, S_DRAIN, S_CPL0, S_CPL1, S_CPL2
  } state_t;

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/tlp_reg_responder_if.sv
// Host->FPGA and FPGA->Host TLP beat streams of the responder.
interface tlp_reg_responder_if;
  logic [63:0] rxData_in;
  logic        rxSOP_in;
  logic        rxEOP_in;
  logic        rxValid_in;
  logic        rxReady_out;
  logic [63:0] txData_out;
  logic        txSOP_out;
  logic        txEOP_out;
  logic        txValid_out;
  logic        txReady_in;

  modport master (
    output rxData_in, rxSOP_in, rxEOP_in, rxValid_in, txReady_in,
    input  rxReady_out, txData_out, txSOP_out, txEOP_out, txValid_out
  );

  modport slave (
    input  rxData_in, rxSOP_in, rxEOP_in, rxValid_in, txReady_in,
    output rxReady_out, txData_out, txSOP_out, txEOP_out, txValid_out
  );
endinterface

// File: rtl/tlp_reg_responder_reg_file.sv
// Byte-enable register file: one write port, two asynchronous read ports.
module tlp_reg_file #(
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [REG_ADDR_BITS-1:0] wr_idx,
  input  logic [3:0]               be,
  input  logic [31:0]              wr_data,
  input  logic [REG_ADDR_BITS-1:0] rd_idx_a,
  output logic [31:0]              rd_data_a,
  input  logic [REG_ADDR_BITS-1:0] rd_idx_b,
  output logic [31:0]              rd_data_b
);
  localparam int N = 1 << REG_ADDR_BITS;

  logic [31:0] mem_q [N];
  logic [31:0] mem_d [N];

  // Merge enabled byte lanes of the write into the addressed register.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // Register storage, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_a = mem_q[rd_idx_a];
  assign rd_data_b = mem_q[rd_idx_b];
endmodule

// File: rtl/tlp_reg_responder.sv
// Single-DW MemWr/MemRd target with CplD responses over a 64-bit TLP stream.
module tlp_reg_responder
  import tlp_reg_responder_pkg::*;
#(
  parameter int REG_ADDR_BITS = 4,
  parameter bit EN_SWAP       = 1'b0
) (
  input  logic                     pcieClk_in,
  input  logic                     reset_in,
  input  logic [12:0]              cfgBusDev_in,
  tlp_reg_responder_if.slave       bus,
  output logic                     regWrValid_out,
  output logic [REG_ADDR_BITS-1:0] regWrIndex_out,
  output logic [31:0]              regWrData_out
);
  state_t                   state_q, state_d;
  logic                     rdy_en_q;
  tlp_dw0_t                 dw0_q, dw0_d;
  tlp_dw1_t                 dw1_q, dw1_d;
  logic [31:0]              dw2_q, dw2_d;
  logic [31:0]              rd_data_q, rd_data_d;
  logic [63:0]              tx_data_q, tx_data_d;
  logic                     tx_sop_q, tx_sop_d, tx_eop_q, tx_eop_d, tx_valid_q, tx_valid_d;
  logic                     wr_vld_q;
  logic [REG_ADDR_BITS-1:0] wr_idx_q;
  logic                     wr_en;
  logic [REG_ADDR_BITS-1:0] wr_idx;
  logic [31:0]              wr_data;
  logic [31:0]              rd_data_a, rd_data_b;
  logic                     rx_acc, is_wr, is_rd;
  tlp_cpl_dw1_t             cpl_dw1;
  tlp_cpl_dw2_t             cpl_dw2;

  // Data DW byte order toggle; headers are never swapped.
  function automatic logic [31:0] data_xform(input logic [31:0] d);
    return EN_SWAP ? swap32(d) : d;
  endfunction

  assign bus.rxReady_out = rdy_en_q && (state_q inside {S_IDLE, S_HDR1, S_WRDATA, S_DRAIN});
  assign rx_acc          = bus.rxValid_in && bus.rxReady_out;
  assign is_wr           = (dw0_q.fmt_type == MEMWR32) && (dw0_q.length == 10'd1);
  assign is_rd           = (dw0_q.fmt_type == MEMRD32) && (dw0_q.length == 10'd1);

  tlp_reg_file #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_regs (
    .clk       (pcieClk_in),
    .rst       (reset_in),
    .we        (wr_en),
    .wr_idx    (wr_idx),
    .be        (dw1_q.first_be),
    .wr_data   (wr_data),
    .rd_idx_a  (bus.rxData_in[REG_ADDR_BITS+1:2]),
    .rd_data_a (rd_data_a),
    .rd_idx_b  (wr_idx_q),
    .rd_data_b (rd_data_b)
  );

  // Receive decode, register write strobe and completion sequencing.
  always_comb begin
    state_d    = state_q;
    dw0_d      = dw0_q;
    dw1_d      = dw1_q;
    dw2_d      = dw2_q;
    rd_data_d  = rd_data_q;
    tx_data_d  = tx_data_q;
    tx_sop_d   = tx_sop_q;
    tx_eop_d   = tx_eop_q;
    tx_valid_d = tx_valid_q;
    wr_en      = 1'b0;
    wr_idx     = bus.rxData_in[REG_ADDR_BITS+1:2];
    wr_data    = data_xform(bus.rxData_in[63:32]);

    cpl_dw1              = '0;
    cpl_dw1.completer_id = {cfgBusDev_in, 3'b000};
    cpl_dw1.byte_count   = 12'd4;
    cpl_dw2              = '0;
    cpl_dw2.req_id       = dw1_q.req_id;
    cpl_dw2.tag          = dw1_q.tag;
    cpl_dw2.lower_addr   = dw2_q[6:0];

    case (state_q)
      S_IDLE, S_HDR1, S_WRDATA, S_DRAIN: begin
        if (rx_acc && bus.rxSOP_in) begin
          // A new header always wins, abandoning any partial TLP.
          dw0_d   = bus.rxData_in[31:0];
          dw1_d   = bus.rxData_in[63:32];
          state_d = bus.rxEOP_in ? S_IDLE : S_HDR1;
        end else if (rx_acc) begin
          case (state_q)
            S_HDR1: begin
              dw2_d = bus.rxData_in[31:0];
              if (is_wr && bus.rxData_in[2]) begin
                wr_en   = bus.rxEOP_in;
                state_d = bus.rxEOP_in ? S_IDLE : S_DRAIN;
              end else if (is_wr) begin
                state_d = bus.rxEOP_in ? S_IDLE : S_WRDATA;
              end else if (is_rd && bus.rxEOP_in) begin
                rd_data_d  = data_xform(rd_data_a);
                tx_data_d  = {cpl_dw1, CPLD, 24'h00_0001};
                tx_sop_d   = 1'b1;
                tx_eop_d   = 1'b0;
                tx_valid_d = 1'b1;
                state_d    = S_CPL0;
              end else begin
                state_d = bus.rxEOP_in ? S_IDLE : S_DRAIN;
              end
            end
            S_WRDATA: begin
              wr_en   = 1'b1;
              wr_idx  = dw2_q[REG_ADDR_BITS+1:2];
              wr_data = data_xform(bus.rxData_in[31:0]);
              state_d = bus.rxEOP_in ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: if (bus.rxEOP_in) state_d = S_IDLE;
            default: ;
          endcase
        end
      end
      S_CPL0: if (bus.txReady_in) begin
        tx_data_d = dw2_q[2] ? {rd_data_q, cpl_dw2} : {32'h0, cpl_dw2};
        tx_sop_d  = 1'b0;
        tx_eop_d  = dw2_q[2];
        state_d   = S_CPL1;
      end
      S_CPL1: if (bus.txReady_in) begin
        if (dw2_q[2]) begin
          tx_valid_d = 1'b0;
          tx_eop_d   = 1'b0;
          state_d    = S_IDLE;
        end else begin
          tx_data_d = {32'h0, rd_data_q};
          tx_eop_d  = 1'b1;
          state_d   = S_CPL2;
        end
      end
      S_CPL2: if (bus.txReady_in) begin
        tx_valid_d = 1'b0;
        tx_eop_d   = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and tx output registers.
  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      rdy_en_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      wr_vld_q   <= 1'b0;
      wr_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= 1'b1;
      tx_data_q  <= tx_data_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      tx_valid_q <= tx_valid_d;
      wr_vld_q   <= wr_en;
      wr_idx_q   <= wr_idx;
    end
  end

  // Header and read-data latches; contents only matter once qualified by state.
  always_ff @(posedge pcieClk_in) begin
    dw0_q     <= dw0_d;
    dw1_q     <= dw1_d;
    dw2_q     <= dw2_d;
    rd_data_q <= rd_data_d;
  end

  assign bus.txData_out  = tx_data_q;
  assign bus.txSOP_out   = tx_sop_q;
  assign bus.txEOP_out   = tx_eop_q;
  assign bus.txValid_out = tx_valid_q;
  assign regWrValid_out  = wr_vld_q;
  assign regWrIndex_out  = wr_idx_q;
  assign regWrData_out   = rd_data_b;
endmodule

// File: tb/tb_tlp_reg_responder.sv
// Directed bench for tlp_reg_responder: writes, reads, backpressure, drops and reset.
module tb_tlp_reg_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] cfg;
  logic        wv;
  logic [3:0]  widx;
  logic [31:0] wdat;
  int          total = 0;
  int          bad   = 0;

  tlp_reg_responder_if bus ();

  tlp_reg_responder #(.REG_ADDR_BITS(4), .EN_SWAP(1'b0)) dut (
    .pcieClk_in     (clk),
    .reset_in       (rst),
    .cfgBusDev_in   (cfg),
    .bus            (bus),
    .regWrValid_out (wv),
    .regWrIndex_out (widx),
    .regWrData_out  (wdat)
  );

  always #5 clk = ~clk;

  // Present one rx beat and hold it until accepted; returns 1ns after the accepting edge.
  task automatic send_beat(input logic [63:0] d, input logic sop, input logic eop);
    int n;
    @(negedge clk);
    bus.rxData_in  = d;
    bus.rxSOP_in   = sop;
    bus.rxEOP_in   = eop;
    bus.rxValid_in = 1'b1;
    n = 0;
    while (!bus.rxReady_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL rx_accept_timeout: rxReady stayed %b, required 1", bus.rxReady_out);
    end
    @(posedge clk);
    #1;
    bus.rxValid_in = 1'b0;
    bus.rxSOP_in   = 1'b0;
    bus.rxEOP_in   = 1'b0;
  endtask

  // Called at a negedge: wait (bounded) for a tx beat, capture it, take it, end at next negedge.
  task automatic get_beat(output logic [63:0] d, output logic sop, output logic eop, output logic ok);
    int n = 0;
    while (!bus.txValid_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok  = bus.txValid_out;
    d   = bus.txData_out;
    sop = bus.txSOP_out;
    eop = bus.txEOP_out;
    bus.txReady_in = 1'b1;
    @(posedge clk);
    #1 bus.txReady_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (bus.rxReady_out !== 1'b0 || bus.txValid_out !== 1'b0 || bus.txSOP_out !== 1'b0 ||
        bus.txEOP_out !== 1'b0 || bus.txData_out !== 64'h0 || wv !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b vld=%b sop=%b eop=%b data=%h wv=%b, required all 0",
               bus.rxReady_out, bus.txValid_out, bus.txSOP_out, bus.txEOP_out, bus.txData_out, wv);
    end
    rst = 1'b0;
    #2;
    total++;
    if (bus.rxReady_out !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge: rxReady=%b, required 0", bus.rxReady_out);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.rxReady_out !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_edge: rxReady=%b, required 1", bus.rxReady_out);
    end
  endtask

  task automatic test_write();
    send_beat(64'h0100_2A0F_4000_0001, 1'b1, 1'b0);
    send_beat(64'hDEAD_BEEF_0000_000C, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (wv !== 1'b1 || widx !== 4'd3 || wdat !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_pulse: v=%b idx=%0d data=%h, required v=1 idx=3 data=deadbeef", wv, widx, wdat);
    end
    @(negedge clk);
    total++;
    if (wv !== 1'b0) begin
      bad++;
      $display("FAIL wr_pulse_width: v=%b, required 0", wv);
    end
  endtask

  task automatic test_read();
    logic [63:0] d; logic s, e, ok;
    send_beat(64'h0100_2A0F_0000_0001, 1'b1, 1'b0);
    send_beat(64'h0000_0000_0000_000C, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (bus.txValid_out !== 1'b1) begin
      bad++;
      $display("FAIL rd_latency: txValid=%b one cycle after EOP, required 1", bus.txValid_out);
    end
    get_beat(d, s, e, ok);
    total++;
    if (!ok || d !== 64'h0100_0004_4A00_0001 || s !== 1'b1 || e !== 1'b0) begin
      bad++;
      $display("FAIL rd_beat0: ok=%b data=%h sop=%b eop=%b, required 010000044a000001 sop=1 eop=0", ok, d, s, e);
    end
    get_beat(d, s, e, ok);
    total++;
    if (!ok || d !== 64'hDEAD_BEEF_0100_2A0C || s !== 1'b0 || e !== 1'b1) begin
      bad++;
      $display("FAIL rd_beat1: ok=%b data=%h sop=%b eop=%b, required deadbeef01002a0c sop=0 eop=1", ok, d, s, e);
    end
    total++;
    if (bus.txValid_out !== 1'b0) begin
      bad++;
      $display("FAIL rd_valid_drop: txValid=%b, required 0", bus.txValid_out);
    end
  endtask

  task automatic test_write_split();
    send_beat(64'h0100_2A0F_4000_0001, 1'b1, 1'b0);
    send_beat(64'hAAAA_AAAA_0000_0008, 1'b0, 1'b0);
    send_beat(64'h5555_5555_1234_5678, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (wv !== 1'b1 || widx !== 4'd2 || wdat !== 32'h12345678) begin
      bad++;
      $display("FAIL wr_split: v=%b idx=%0d data=%h, required v=1 idx=2 data=12345678", wv, widx, wdat);
    end
  endtask

  task automatic test_read_3beat();
    logic [63:0] d; logic s, e, ok;
    send_beat(64'h0100_2A0F_0000_0001, 1'b1, 1'b0);
    send_beat(64'h0000_0000_0000_0008, 1'b0, 1'b1);
    @(negedge clk);
    get_beat(d, s, e, ok);
    total++;
    if (!ok || d !== 64'h0100_0004_4A00_0001 || s !== 1'b1 || e !== 1'b0) begin
      bad++;
      $display("FAIL rd3_beat0: ok=%b data=%h sop=%b eop=%b, required 010000044a000001 sop=1 eop=0", ok, d, s, e);
    end
    get_beat(d, s, e, ok);
    total++;
    if (!ok || d !== 64'h0000_0000_0100_2A08 || s !== 1'b0 || e !== 1'b0) begin
      bad++;
      $display("FAIL rd3_beat1: ok=%b data=%h sop=%b eop=%b, required 0000000001002a08 sop=0 eop=0", ok, d, s, e);
    end
    get_beat(d, s, e, ok);
    total++;
    if (!ok || d !== 64'h0000_0000_1234_5678 || s !== 1'b0 || e !== 1'b1) begin
      bad++;
      $display("FAIL rd3_beat2: ok=%b data=%h sop=%b eop=%b, required 0000000012345678 sop=0 eop=1", ok, d, s, e);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d; logic s, e, ok;
    send_beat(64'h0100_2A0F_0000_0001, 1'b1, 1'b0);
    send_beat(64'h0000_0000_0000_000C, 1'b0, 1'b1);
    @(negedge clk);
    get_beat(d, s, e, ok);
    total++;
    if (!ok || d !== 64'h0100_0004_4A00_0001 || s !== 1'b1) begin
      bad++;
      $display("FAIL bp_beat0: ok=%b data=%h sop=%b, required 010000044a000001 sop=1", ok, d, s);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.txValid_out !== 1'b1 || bus.txData_out !== 64'hDEAD_BEEF_0100_2A0C ||
          bus.txSOP_out !== 1'b0 || bus.txEOP_out !== 1'b1 || bus.rxReady_out !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: vld=%b data=%h sop=%b eop=%b rdy=%b, required 1 deadbeef01002a0c 0 1 0",
                 i, bus.txValid_out, bus.txData_out, bus.txSOP_out, bus.txEOP_out, bus.rxReady_out);
      end
      @(negedge clk);
    end
    get_beat(d, s, e, ok);
    total++;
    if (!ok || d !== 64'hDEAD_BEEF_0100_2A0C || s !== 1'b0 || e !== 1'b1) begin
      bad++;
      $display("FAIL bp_beat1: ok=%b data=%h sop=%b eop=%b, required deadbeef01002a0c sop=0 eop=1", ok, d, s, e);
    end
  endtask

  task automatic test_byte_enable();
    send_beat(64'h0100_2A02_4000_0001, 1'b1, 1'b0);
    send_beat(64'h0000_5500_0000_000C, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (wv !== 1'b1 || widx !== 4'd3 || wdat !== 32'hDEAD55EF) begin
      bad++;
      $display("FAIL wr_be: v=%b idx=%0d data=%h, required v=1 idx=3 data=dead55ef", wv, widx, wdat);
    end
  endtask

  task automatic test_alias();
    logic [63:0] d; logic s, e, ok;
    send_beat(64'h0123_770F_0000_0001, 1'b1, 1'b0);
    send_beat(64'h0000_0000_0000_004C, 1'b0, 1'b1);
    @(negedge clk);
    get_beat(d, s, e, ok);
    get_beat(d, s, e, ok);
    total++;
    if (!ok || d !== 64'hDEAD_55EF_0123_774C || e !== 1'b1) begin
      bad++;
      $display("FAIL rd_alias: ok=%b data=%h eop=%b, required dead55ef0123774c eop=1", ok, d, e);
    end
  endtask

  task automatic test_drop_and_reset();
    logic [63:0] d; logic s, e, ok;
    logic        seen;
    send_beat(64'h0100_2A0F_2000_0001, 1'b1, 1'b0);
    send_beat(64'h0000_0000_0000_0000, 1'b0, 1'b0);
    send_beat(64'h0000_0000_0000_000C, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.txValid_out !== 1'b0 || wv !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL drop_4dw: tx or write activity seen=%b, required none", seen);
    end
    send_beat(64'h0100_2A0F_4000_0001, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus.rxReady_out !== 1'b0 || bus.txValid_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: rdy=%b vld=%b, required 0 0", bus.rxReady_out, bus.txValid_out);
    end
    @(negedge clk);
    rst = 1'b0;
    send_beat(64'hDEAD_BEEF_0000_000C, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wv !== 1'b0 || bus.txValid_out !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL headerless_beat: activity seen=%b, required none", seen);
    end
    send_beat(64'h0100_2A0F_0000_0001, 1'b1, 1'b0);
    send_beat(64'h0000_0000_0000_000C, 1'b0, 1'b1);
    @(negedge clk);
    get_beat(d, s, e, ok);
    total++;
    if (!ok || d !== 64'h0100_0004_4A00_0001 || s !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_beat0: ok=%b data=%h sop=%b, required 010000044a000001 sop=1", ok, d, s);
    end
    get_beat(d, s, e, ok);
    total++;
    if (!ok || d !== 64'h0000_0000_0100_2A0C || e !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_beat1: ok=%b data=%h eop=%b, required 0000000001002a0c eop=1", ok, d, e);
    end
  endtask

  initial begin
    cfg            = 13'h0020;
    bus.rxData_in  = '0;
    bus.rxSOP_in   = 1'b0;
    bus.rxEOP_in   = 1'b0;
    bus.rxValid_in = 1'b0;
    bus.txReady_in = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_write_split();
    test_read_3beat();
    test_backpressure();
    test_byte_enable();
    test_alias();
    test_drop_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
    $fatal(1);
  end
endmodule
